// File: rtl/zx_mem_pkg.sv
// Shared types and width helpers for the zx memory arbiter.
package zx_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_REFRESH = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/zx_mem_rrpick.sv
// Combinational picker: round-robin from 'start' when RR != 0, else lowest index wins.
module zx_mem_rrpick #(
    parameter int unsigned CH = 4,
    parameter int unsigned RR = 1,
    parameter int unsigned IW = 2
) (
    input  logic [CH-1:0] req,
    input  logic [IW-1:0] start,
    output logic [CH-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            k = (RR != 0) ? IW'((32'(start) + i) % CH) : IW'(i);
            if (!any && req[k]) begin
                gnt[k] = 1'b1;
                idx    = k;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zx_mem_arbiter.sv
// N-channel arbiter in front of one external memory, with periodic refresh.
// Define ZX_MEM_ROMPROT_EN to ack writes below ROM_TOP without strobing memWr.
module zx_mem_arbiter
    import zx_mem_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned AW          = 19,
    parameter int unsigned DW          = 8,
    parameter int unsigned RR          = 1,
    parameter int unsigned LAT         = 2,
    parameter int unsigned RFSH_PERIOD = 256,
    parameter int unsigned RFSH_CYCLES = 4
`ifdef ZX_MEM_ROMPROT_EN
    ,
    parameter logic [AW-1:0] ROM_TOP   = AW'('h08000)
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CH-1:0]    req,
    input  logic [CH-1:0]    we,
    input  logic [CH*AW-1:0] a,
    input  logic [CH*DW-1:0] d,
    output logic [CH-1:0]    ack,
    output logic [DW-1:0]    q,
    input  logic             memReady,
    output logic             memRd,
    output logic             memWr,
    output logic             memRf,
    output logic [AW-1:0]    memA,
    output logic [DW-1:0]    memD,
    input  logic [DW-1:0]    memQ
);

    localparam int unsigned IW = cw(CH);
    localparam int unsigned LW = cw(LAT);
    localparam int unsigned RW = cw(RFSH_CYCLES);
    localparam int unsigned PW = cw(RFSH_PERIOD);

    state_e          state, nstate;
    logic [CH-1:0]   cand, gnt, cur;
    logic [IW-1:0]   gidx, rrptr;
    logic            any, cur_we;
    logic [AW-1:0]   gnt_a;
    logic [DW-1:0]   gnt_d;
    logic            gnt_we;
    logic [LW-1:0]   lcnt;
    logic [RW-1:0]   rcnt;
    logic [PW-1:0]   pcnt;
    logic            rf_pend, rf_wrap;
    logic            prot_c, go_c, rf_c, rom_ack_c, done_c, rf_done_c;

    // The channel acked this clock sits out one IDLE decision.
    assign cand = req & ~ack;

    zx_mem_rrpick #(.CH(CH), .RR(RR), .IW(IW)) u_pick (
        .req   (cand),
        .start (rrptr),
        .gnt   (gnt),
        .idx   (gidx),
        .any   (any)
    );

    always_comb begin
        gnt_a  = '0;
        gnt_d  = '0;
        gnt_we = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (gnt[i]) begin
                gnt_a  = a[i*AW +: AW];
                gnt_d  = d[i*DW +: DW];
                gnt_we = we[i];
            end
        end
    end

`ifdef ZX_MEM_ROMPROT_EN
    assign prot_c = gnt_we && (gnt_a < ROM_TOP);
`else
    assign prot_c = 1'b0;
`endif

    assign rf_wrap = (RFSH_PERIOD != 0) && (pcnt == PW'(RFSH_PERIOD - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (rf_c)      nstate = ST_REFRESH;
                else if (go_c) nstate = ST_ACCESS;
            end
            ST_ACCESS:  if (done_c)    nstate = ST_IDLE;
            ST_REFRESH: if (rf_done_c) nstate = ST_IDLE;
            default:                   nstate = ST_IDLE;
        endcase
    end

    // Refresh beats any request; protected writes ack without leaving IDLE.
    always_comb begin
        go_c      = 1'b0;
        rf_c      = 1'b0;
        rom_ack_c = 1'b0;
        done_c    = 1'b0;
        rf_done_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memReady) begin
                    if (rf_pend)     rf_c      = 1'b1;
                    else if (any) begin
                        if (prot_c)  rom_ack_c = 1'b1;
                        else         go_c      = 1'b1;
                    end
                end
            end
            ST_ACCESS:  done_c    = (lcnt == LW'(LAT - 1));
            ST_REFRESH: rf_done_c = (rcnt == RW'(RFSH_CYCLES - 1));
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            memRd   <= 1'b0;
            memWr   <= 1'b0;
            memRf   <= 1'b0;
            memA    <= '0;
            memD    <= '0;
            ack     <= '0;
            q       <= '0;
            cur     <= '0;
            cur_we  <= 1'b0;
            rrptr   <= '0;
            lcnt    <= '0;
            rcnt    <= '0;
            pcnt    <= '0;
            rf_pend <= 1'b0;
        end else begin
            memRd <= go_c & ~gnt_we;
            memWr <= go_c & gnt_we;
            memRf <= rf_c;
            ack   <= done_c ? cur : (rom_ack_c ? gnt : '0);
            if (go_c) begin
                memA   <= gnt_a;
                memD   <= gnt_d;
                cur    <= gnt;
                cur_we <= gnt_we;
                rrptr  <= IW'((32'(gidx) + 32'd1) % CH);
            end
            if (done_c && !cur_we) q <= memQ;
            lcnt    <= (state == ST_ACCESS)  ? lcnt + LW'(1) : '0;
            rcnt    <= (state == ST_REFRESH) ? rcnt + RW'(1) : '0;
            pcnt    <= rf_wrap ? '0 : pcnt + PW'(1);
            // A new period re-arms even while the previous one is being served.
            rf_pend <= rf_wrap | (rf_pend & ~rf_c);
        end
    end

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Directed bench: round-robin, fixed-priority and refresh-enabled arbiters share one stimulus.
module tb_zx_mem_arbiter;

    localparam int CH = 4;
    localparam int AW = 19;
    localparam int DW = 8;

    logic             clock, reset, memReady;
    logic [CH-1:0]    req, we;
    logic [CH*AW-1:0] a;
    logic [CH*DW-1:0] d;
    logic [DW-1:0]    memq;

    logic [CH-1:0] ack_rr, ack_fp, ack_rf;
    logic [DW-1:0] q_rr, q_fp, q_rf, md_rr, md_fp, md_rf;
    logic [AW-1:0] ma_rr, ma_fp, ma_rf;
    logic          rd_rr, wr_rr, rf_rr, rd_fp, wr_fp, rf_fp, rd_rf, wr_rf, rf_rf;

    int n_tests, n_fail;

    zx_mem_arbiter #(.RR(1), .RFSH_PERIOD(0)) u_rr (
        .clock(clock), .reset(reset), .req(req), .we(we), .a(a), .d(d),
        .ack(ack_rr), .q(q_rr), .memReady(memReady), .memRd(rd_rr), .memWr(wr_rr),
        .memRf(rf_rr), .memA(ma_rr), .memD(md_rr), .memQ(memq)
    );

    zx_mem_arbiter #(.RR(0), .RFSH_PERIOD(0)) u_fp (
        .clock(clock), .reset(reset), .req(req), .we(we), .a(a), .d(d),
        .ack(ack_fp), .q(q_fp), .memReady(memReady), .memRd(rd_fp), .memWr(wr_fp),
        .memRf(rf_fp), .memA(ma_fp), .memD(md_fp), .memQ(memq)
    );

    zx_mem_arbiter #(.RR(1), .RFSH_PERIOD(16)) u_rf (
        .clock(clock), .reset(reset), .req(req), .we(we), .a(a), .d(d),
        .ack(ack_rf), .q(q_rf), .memReady(memReady), .memRd(rd_rf), .memWr(wr_rf),
        .memRf(rf_rf), .memA(ma_rf), .memD(md_rf), .memQ(memq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        we       = '0;
        memReady = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_ch(input int n, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a[n*AW +: AW] = addr;
        d[n*DW +: DW] = data;
    endtask

    // Waits for the next ack from u_rr (sel 0) or u_fp (sel 1), bounded.
    task automatic wait_ack(input int sel, output logic [CH-1:0] got, output int cyc);
        got = '0;
        cyc = 0;
        for (int i = 0; i < 12 && got == '0; i++) begin
            tick();
            cyc++;
            got = (sel == 0) ? ack_rr : ack_fp;
        end
        if (got == '0) chk("ack_timeout", 32'(cyc), 32'd0);
    endtask

    logic [CH-1:0] got;
    int            cyc;
    logic [CH-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [CH-1:0] exp_fp [4] = '{4'b0010, 4'b0001, 4'b0100, 4'b1000};
    logic [CH-1:0] nxt_fp [4] = '{4'b1101, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; req = '0; we = '0; a = '0; d = '0; memq = 8'hA5; memReady = 1'b1;

        // Reset state
        do_reset();
        chk("rst_rr_ctl", {ack_rr, rd_rr, wr_rr, rf_rr}, 0);
        chk("rst_rr_memA", 32'(ma_rr), 0);
        chk("rst_rr_memD_q", {md_rr, q_rr}, 0);
        chk("rst_fp_a", 32'(ma_fp), 0);
        chk("rst_fp_o", {ack_fp, rd_fp, wr_fp, rf_fp, q_fp, md_fp}, 0);
        chk("rst_rf_a", 32'(ma_rf), 0);
        chk("rst_rf_o", {ack_rf, rd_rf, wr_rf, rf_rf, q_rf, md_rf}, 0);

        // Single read on ch1
        set_ch(1, 19'h12345, 8'h00);
        req = 4'b0010;
        tick();
        chk("t1_rd", 32'(rd_rr), 1);
        chk("t1_wr", 32'(wr_rr), 0);
        chk("t1_memA", 32'(ma_rr), 32'h12345);
        chk("t1_ack_early", 32'(ack_rr), 0);
        tick();
        chk("t1_rd_pulse", {ack_rr, rd_rr}, 0);
        tick();
        chk("t1_ack", 32'(ack_rr), 32'b0010);
        chk("t1_q", 32'(q_rr), 32'hA5);
        req = '0;
        repeat (2) begin
            tick();
            chk("t1_no_second", {rd_rr, wr_rr, ack_rr}, 0);
        end

        // Single write on ch3; q keeps the last read value
        set_ch(3, 19'h0ABCD, 8'h3C);
        we = 4'b1000; req = 4'b1000; memq = 8'h5A;
        tick();
        chk("t1w_wr", {wr_rr, rd_rr}, 32'b10);
        chk("t1w_memA", 32'(ma_rr), 32'h0ABCD);
        chk("t1w_memD", 32'(md_rr), 32'h3C);
        tick();
        tick();
        chk("t1w_ack", 32'(ack_rr), 32'b1000);
        chk("t1w_q_hold", 32'(q_rr), 32'hA5);
        req = '0; we = '0; memq = 8'hA5;

        // Round-robin with all channels held
        do_reset();
        for (int i = 0; i < CH; i++) set_ch(i, 19'(32'h100 + i), 8'(i));
        req = 4'b1111;
        tick();
        chk("t2_first_rd", 32'(rd_rr), 1);
        chk("t2_first_memA", 32'(ma_rr), 32'h100);
        for (int k = 0; k < 5; k++) begin
            wait_ack(0, got, cyc);
            chk("t2_rr_ack", 32'(got), 32'(exp_rr[k]));
            chk("t2_rr_gap", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
        end
        req = '0;
        tick();
        tick();

        // Fixed priority: lowest requesting index wins, acked channel drops req
        do_reset();
        req = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, got, cyc);
            chk("t2_fp_ack", 32'(got), 32'(exp_fp[k]));
            req = nxt_fp[k];
        end
        tick();

        // Refresh pending on the same clock as req[2]
        do_reset();
        set_ch(2, 19'h02222, 8'h00);
        repeat (16) tick();
        chk("t3_no_rf_yet", 32'(rf_rf), 0);
        req = 4'b0100;
        tick();
        chk("t3_rf", {rf_rf, rd_rf}, 32'b10);
        repeat (4) begin
            tick();
            chk("t3_busy", {rd_rf, wr_rf, rf_rf}, 0);
        end
        tick();
        chk("t3_rd", 32'(rd_rf), 1);
        chk("t3_memA", 32'(ma_rf), 32'h02222);
        tick();
        tick();
        chk("t3_ack", 32'(ack_rf), 32'b0100);
        req = '0;

        // Reset one clock after memWr aborts the access
        do_reset();
        set_ch(0, 19'h10000, 8'h77);
        we = 4'b0001; req = 4'b0001;
        tick();
        chk("t4_wr", 32'(wr_rr), 1);
        chk("t4_memD", 32'(md_rr), 32'h77);
        tick();
        reset = 1'b1;
        tick();
        chk("t4_abort", {ack_rr, rd_rr, wr_rr, rf_rr}, 0);
        chk("t4_memA", 32'(ma_rr), 0);
        tick();
        reset = 1'b0;
        chk("t4_held", {ack_rr, wr_rr}, 0);
        tick();
        chk("t4_regrant", 32'(wr_rr), 1);
        tick();
        tick();
        chk("t4_ack", 32'(ack_rr), 32'b0001);
        req = '0; we = '0;

        // Writes below and at the ROM boundary
        do_reset();
        set_ch(0, 19'h01000, 8'h11);
        we = 4'b0001; req = 4'b0001;
        tick();
`ifdef ZX_MEM_ROMPROT_EN
        chk("t5_rom_ack", 32'(ack_rr), 32'b0001);
        chk("t5_rom_nowr", 32'(wr_rr), 0);
        req = '0;
        tick();
        chk("t5_rom_idle", {ack_rr, wr_rr}, 0);
`else
        chk("t5_low_wr", 32'(wr_rr), 1);
        chk("t5_low_memA", 32'(ma_rr), 32'h01000);
        tick();
        tick();
        chk("t5_low_ack", 32'(ack_rr), 32'b0001);
        req = '0;
        tick();
`endif
        set_ch(0, 19'h08000, 8'h22);
        req = 4'b0001;
        tick();
        chk("t5_top_wr", 32'(wr_rr), 1);
        chk("t5_top_memA", 32'(ma_rr), 32'h08000);
        tick();
        tick();
        chk("t5_top_ack", 32'(ack_rr), 32'b0001);
        req = '0; we = '0;

        // memReady low stalls everything
        do_reset();
        memReady = 1'b0;
        set_ch(0, 19'h00042, 8'h00);
        req = 4'b0001;
        repeat (5) begin
            tick();
            chk("t6_stall", {ack_rr, rd_rr, wr_rr, rf_rr}, 0);
        end
        memReady = 1'b1;
        tick();
        chk("t6_rd", 32'(rd_rr), 1);
        chk("t6_memA", 32'(ma_rr), 32'h00042);
        tick();
        tick();
        chk("t6_ack", 32'(ack_rr), 32'b0001);
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
